// File: rtl/demodulate_mc.sv
// Multi-cycle FM demodulator: per-channel conjugate product of consecutive IQ
// samples, arctangent approximation via an iterative restoring divider, then
// output gain. One result every WIDTH+4 cycles; channels interleave round-robin.
module demodulate_mc #(
  parameter int WIDTH    = 32,
  parameter int BITS     = 10,
  parameter int CHANNELS = 2,
  parameter int GAIN     = 758,
  parameter int QUAD1    = 804,
  parameter int QUAD3    = 2412,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_fifos_empty,
  output logic                    input_rd_en,
  input  logic signed [WIDTH-1:0] real_in,
  input  logic signed [WIDTH-1:0] imag_in,
  input  logic                    hist_clr,
  input  logic                    out_full,
  output logic signed [WIDTH-1:0] demod_out,
  output logic [CW-1:0]           chan_out,
  output logic                    wr_en_out,
  output logic                    busy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CHAN_MAX = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, ANGLE, OUT} state_t;

  // Remove BITS fraction bits, truncating toward zero (bias negatives first).
  function automatic logic signed [2*WIDTH-1:0] dq(input logic signed [2*WIDTH-1:0] v);
    logic signed [2*WIDTH-1:0] bias;
    bias = v[2*WIDTH-1] ? (2*WIDTH)'((1 << BITS) - 1) : '0;
    return (v + bias) >>> BITS;
  endfunction

  // Full-precision signed product at twice the word width.
  function automatic logic signed [2*WIDTH-1:0] mul(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ae;
    logic signed [2*WIDTH-1:0] be;
    ae = a;
    be = b;
    return ae * be;
  endfunction

  state_t state;
  logic [CW-1:0] chan;
  logic [CW-1:0] tag;
  logic signed [WIDTH-1:0] hist_r [CHANNELS];
  logic signed [WIDTH-1:0] hist_i [CHANNELS];

  logic signed [WIDTH-1:0] curr_r_p0, curr_i_p0, prev_r_p0, prev_i_p0;
  logic [WIDTH-1:0]        den_p1;
  logic signed [WIDTH-1:0] base_p1;
  logic                    num_neg_p1, y_neg_p1;
  logic [WIDTH-1:0]        quo_p2, rem_p2;
  logic [IW-1:0]           iter;

  logic signed [WIDTH-1:0] x, y, abs_y, diff, num, den_c;
  logic [WIDTH-1:0]        mag;
  logic [WIDTH:0]          rem_sh;
  logic                    ge;
  logic [WIDTH-1:0]        rem_nx, quo_nx;
  logic signed [WIDTH-1:0] r, angle_raw, angle, result;

  assign input_rd_en = reset & (state == IDLE) & ~input_fifos_empty & ~hist_clr;
  assign wr_en_out   = (state == OUT) & ~out_full;
  assign busy        = (state != IDLE);

  // MULT stage: conjugate product, then numerator/denominator of the atan ratio.
  always_comb begin
    x     = WIDTH'(dq(mul(prev_r_p0, curr_r_p0)) - dq(-mul(prev_i_p0, curr_i_p0)));
    y     = WIDTH'(dq(mul(prev_r_p0, curr_i_p0)) + dq(-mul(prev_i_p0, curr_r_p0)));
    abs_y = (y[WIDTH-1] ? -y : y) + WIDTH'(1);
    if (!x[WIDTH-1]) begin
      diff  = x - abs_y;
      den_c = x + abs_y;
    end else begin
      diff  = x + abs_y;
      den_c = abs_y - x;
    end
    num = diff <<< BITS;
    mag = num[WIDTH-1] ? -num : num;
  end

  // DIV stage: one restoring-division step per cycle.
  always_comb begin
    rem_sh = {rem_p2, quo_p2[WIDTH-1]};
    ge     = rem_sh >= {1'b0, den_p1};
    rem_nx = ge ? WIDTH'(rem_sh - {1'b0, den_p1}) : rem_sh[WIDTH-1:0];
    quo_nx = {quo_p2[WIDTH-2:0], ge};
  end

  // ANGLE stage: signed quotient to phase difference, then output gain.
  always_comb begin
    r         = num_neg_p1 ? -$signed(quo_p2) : $signed(quo_p2);
    angle_raw = WIDTH'(base_p1 - dq(mul(WIDTH'(QUAD1), r)));
    angle     = y_neg_p1 ? -angle_raw : angle_raw;
    result    = WIDTH'(dq(mul(angle, WIDTH'(GAIN))));
  end

  // Control FSM, channel history and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      chan      <= '0;
      tag       <= '0;
      demod_out <= '0;
      chan_out  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        hist_r[k] <= '0;
        hist_i[k] <= '0;
      end
    end else begin
      if (hist_clr) begin
        for (int k = 0; k < CHANNELS; k++) begin
          hist_r[k] <= '0;
          hist_i[k] <= '0;
        end
        chan <= '0;
      end else if (input_rd_en) begin
        hist_r[chan] <= real_in;
        hist_i[chan] <= imag_in;
        chan         <= (chan == CHAN_MAX) ? '0 : chan + 1'b1;
      end
      if (input_rd_en) tag <= chan;
      case (state)
        IDLE:  if (input_rd_en) state <= MULT;
        MULT:  state <= DIV;
        DIV:   if (iter == LAST) state <= ANGLE;
        ANGLE: begin
          state     <= OUT;
          demod_out <= result;
          chan_out  <= tag;
        end
        OUT:   if (!out_full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath operand and divider registers (no reset needed).
  always_ff @(posedge clk) begin
    // p0: sample capture at accept
    if (input_rd_en) begin
      curr_r_p0 <= real_in;
      curr_i_p0 <= imag_in;
      prev_r_p0 <= hist_r[chan];
      prev_i_p0 <= hist_i[chan];
    end
    // p1: ratio operands, divider load
    if (state == MULT) begin
      den_p1     <= den_c;
      base_p1    <= x[WIDTH-1] ? WIDTH'(QUAD3) : WIDTH'(QUAD1);
      num_neg_p1 <= num[WIDTH-1];
      y_neg_p1   <= y[WIDTH-1];
      quo_p2     <= mag;
      rem_p2     <= '0;
      iter       <= '0;
    end
    // p2: iterative division
    if (state == DIV) begin
      quo_p2 <= quo_nx;
      rem_p2 <= rem_nx;
      iter   <= iter + 1'b1;
    end
  end

endmodule

// File: tb/tb_demodulate_mc.sv
// Directed bench for demodulate_mc: vector table plus multi-cycle corner sequences.
module tb_demodulate_mc;

  localparam int W = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               input_fifos_empty;
  logic               input_rd_en;
  logic signed [W-1:0] real_in, imag_in;
  logic               hist_clr;
  logic               out_full;
  logic signed [W-1:0] demod_out;
  logic [0:0]         chan_out;
  logic               wr_en_out;
  logic               busy;

  int errors = 0;
  int checks = 0;

  demodulate_mc #(.WIDTH(W), .BITS(10), .CHANNELS(2), .GAIN(758), .QUAD1(804), .QUAD3(2412)) dut (
    .clk(clk), .reset(reset), .input_fifos_empty(input_fifos_empty), .input_rd_en(input_rd_en),
    .real_in(real_in), .imag_in(imag_in), .hist_clr(hist_clr), .out_full(out_full),
    .demod_out(demod_out), .chan_out(chan_out), .wr_en_out(wr_en_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    bit                  clr;
    int                  ch;
    int                  dm;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
  endtask

  // Present a sample and return just after the accepting edge.
  task automatic do_accept(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    @(negedge clk);
    real_in = re;
    imag_in = im;
    input_fifos_empty = 1'b0;
    #1;
    for (int n = 0; n < 200 && !input_rd_en; n++) begin
      @(negedge clk);
      #1;
    end
    if (!input_rd_en) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got rd_en=0 expected 1");
    end
    @(posedge clk);
    #1 input_fifos_empty = 1'b1;
  endtask

  // Wait for the write strobe and compare result, tag and latency.
  task automatic wait_result(input int exp_d, input int exp_c, input int exp_lat, input string name);
    bit seen;
    int k;
    seen = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0 && exp_lat >= 0) check({name, "_busy"}, busy, 1);
      if (wr_en_out) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no wr_en_out expected a write", name);
    end else begin
      check({name, "_demod"}, demod_out, exp_d);
      check({name, "_chan"}, chan_out, exp_c);
      if (exp_lat >= 0) check({name, "_latency"}, k, exp_lat);
    end
  endtask

  initial begin
    int wr_seen, rd_seen, changed, pulses;
    logic signed [W-1:0] held;
    int rd_idx[$];
    int chans[$];

    tbl[0]  = '{re: 1024,  im: 0,     clr: 0, ch: 0, dm: 1190};
    tbl[1]  = '{re: 1024,  im: 0,     clr: 0, ch: 1, dm: 1190};
    tbl[2]  = '{re: 1024,  im: 0,     clr: 0, ch: 0, dm: 1};
    tbl[3]  = '{re: 0,     im: -1024, clr: 0, ch: 1, dm: -1190};
    tbl[4]  = '{re: 0,     im: 1024,  clr: 0, ch: 0, dm: 1190};
    tbl[5]  = '{re: 0,     im: 1024,  clr: 0, ch: 1, dm: 2379};
    tbl[6]  = '{re: 0,     im: 1024,  clr: 1, ch: 0, dm: 1190};
    tbl[7]  = '{re: -1024, im: 0,     clr: 0, ch: 1, dm: 1190};
    tbl[8]  = '{re: 0,     im: 1024,  clr: 0, ch: 0, dm: 1};
    tbl[9]  = '{re: -1024, im: 0,     clr: 0, ch: 1, dm: 1};
    tbl[10] = '{re: 512,   im: 512,   clr: 0, ch: 0, dm: -595};
    tbl[11] = '{re: 512,   im: -512,  clr: 0, ch: 1, dm: 1785};

    reset = 1'b0;
    input_fifos_empty = 1'b0;
    hist_clr = 1'b0;
    out_full = 1'b0;
    real_in = '0;
    imag_in = '0;
    repeat (3) @(negedge clk);
    check("reset_demod", demod_out, 0);
    check("reset_chan", chan_out, 0);
    check("reset_wr", wr_en_out, 0);
    check("reset_busy", busy, 0);
    check("reset_rd", input_rd_en, 0);
    input_fifos_empty = 1'b1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].clr) pulse_clr();
      do_accept(tbl[i].re, tbl[i].im);
      wait_result(tbl[i].dm, tbl[i].ch, W + 2, $sformatf("vec%0d", i));
    end

    // Output back-pressure: result held, nothing accepted, then one write.
    pulse_clr();
    out_full = 1'b1;
    do_accept(1024, 0);
    repeat (W + 6) @(negedge clk);
    input_fifos_empty = 1'b0;
    held = demod_out;
    wr_seen = 0; rd_seen = 0; changed = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_en_out) wr_seen++;
      if (input_rd_en) rd_seen++;
      if (demod_out !== held) changed++;
    end
    check("stall_wr", wr_seen, 0);
    check("stall_rd", rd_seen, 0);
    check("stall_hold", changed, 0);
    check("stall_demod", demod_out, 1190);
    check("stall_chan", chan_out, 0);
    out_full = 1'b0;
    input_fifos_empty = 1'b1;
    #1;
    pulses = wr_en_out ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en_out) pulses++;
    end
    check("stall_release_pulses", pulses, 1);

    // History clear during an in-flight division.
    pulse_clr();
    do_accept(1024, 0);
    wait_result(1190, 0, W + 2, "clr_a");
    do_accept(1024, 0);
    wait_result(1190, 1, W + 2, "clr_b");
    do_accept(1024, 0);
    repeat (10) @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    wait_result(1, 0, -1, "clr_inflight");
    do_accept(1024, 0);
    wait_result(1190, 0, W + 2, "clr_next");

    // Reset asserted mid-division.
    do_accept(1024, 0);
    wait_result(1190, 1, W + 2, "rst_pre");
    do_accept(1024, 0);
    repeat (10) @(negedge clk);
    input_fifos_empty = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mid_demod", demod_out, 0);
    check("rst_mid_chan", chan_out, 0);
    check("rst_mid_wr", wr_en_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd", input_rd_en, 0);
    @(negedge clk);
    input_fifos_empty = 1'b1;
    reset = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (wr_en_out) wr_seen++;
    end
    check("rst_no_write", wr_seen, 0);
    do_accept(1024, 0);
    wait_result(1190, 0, W + 2, "rst_after");

    // Continuous source: fixed accept cadence, alternating channels.
    pulse_clr();
    @(negedge clk);
    real_in = 1024;
    imag_in = 0;
    input_fifos_empty = 1'b0;
    #1;
    for (int n = 0; n < 5 * (W + 4); n++) begin
      if (input_rd_en) rd_idx.push_back(n);
      if (wr_en_out) chans.push_back(int'(chan_out));
      @(negedge clk);
      #1;
    end
    input_fifos_empty = 1'b1;
    check("cont_accept_count_ok", (rd_idx.size() >= 4) ? 1 : 0, 1);
    check("cont_write_count_ok", (chans.size() >= 4) ? 1 : 0, 1);
    for (int i = 1; i < 4 && i < rd_idx.size(); i++)
      check($sformatf("cont_period%0d", i), rd_idx[i] - rd_idx[i-1], W + 4);
    for (int i = 0; i < 4 && i < chans.size(); i++)
      check($sformatf("cont_chan%0d", i), chans[i], i % 2);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
